pc_unit: RTL and testbench

PC_UNIT -- requirements
Module: pc_unit

---
 rtl/pc_pkg.sv | 12 +
 rtl/pc_ras.sv | 69 ++++++
 rtl/pc_unit.sv | 113 +++++++++++
 tb/tb_pc_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: default widths and FSM state type.
package pc_pkg;

   localparam int unsigned XLEN_DEF        = 32;
   localparam int unsigned INSTR_BYTES_DEF = 4;

   typedef enum logic {
      StBoot,
      StRun
   } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer where a push into a full stack overwrites the
// oldest entry. A simultaneous push and pop replaces the top in place.
module pc_ras
   import pc_pkg::*;
#(
   parameter int unsigned XLEN      = XLEN_DEF,
   parameter int unsigned RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_data,
   output logic [XLEN-1:0] top,
   output logic            empty
);

   localparam int unsigned PtrW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned Slots = 1 << PtrW;
   localparam int unsigned CntW  = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0] mem_q [Slots];
   logic [PtrW-1:0] ptr_q, ptr_d, wr_ptr;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            wr_en;

   assign top   = mem_q[ptr_q];
   assign empty = (cnt_q == '0);

   // Next pointer/count and write slot; ptr_q always addresses the newest entry.
   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_ptr = ptr_q;
      if (push && pop && !empty) begin
         wr_en = 1'b1;
      end else if (push) begin
         ptr_d  = ptr_q + 1'b1;
         wr_ptr = ptr_d;
         wr_en  = 1'b1;
         if (cnt_q != CntW'(RAS_DEPTH)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (pop && !empty) begin
         ptr_d = ptr_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Pointer and occupancy; reset empties the stack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr] <= push_data;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: boot/run FSM, stall/advance handshake, trap/redirect flush with
// target alignment, and an optional return-address stack (enabled by PC_UNIT_RAS_EN).
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     INSTR_BYTES  = INSTR_BYTES_DEF,
   parameter int unsigned     RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fetch_ready,
   output logic            fetch_valid,
   output logic [XLEN-1:0] pc,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_target,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            call_valid,
   input  logic            ret_valid,
   output logic            ras_empty,
   output logic            misaligned_err
);

   localparam int unsigned     AlignBits = $clog2(INSTR_BYTES);
   localparam logic [XLEN-1:0] AlignMask = {XLEN{1'b1}} << AlignBits;

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d, pc_seq, load_tgt, ras_top;
   logic            err_q, err_d, fire, load_en, ras_push, ras_pop, ras_empty_int;

   assign fetch_valid    = (state_q == StRun);
   assign pc             = pc_q;
   assign misaligned_err = err_q;
   assign ras_empty      = ras_empty_int;
   assign fire           = fetch_valid && fetch_ready;
   assign pc_seq         = pc_q + XLEN'(INSTR_BYTES);

   // Next-pc selection: trap > redirect > return (stack non-empty) > sequential on fire.
   always_comb begin
      state_d  = StRun;
      pc_d     = pc_q;
      err_d    = err_q;
      load_en  = 1'b0;
      load_tgt = '0;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      case (state_q)
         StBoot: state_d = StRun;
         StRun: begin
            if (trap_valid) begin
               load_en  = 1'b1;
               load_tgt = trap_target;
            end else if (redirect_valid) begin
               load_en  = 1'b1;
               load_tgt = redirect_target;
            end else if (fire) begin
               ras_push = call_valid;
               if (ret_valid && !ras_empty_int) begin
                  ras_pop  = 1'b1;
                  load_en  = 1'b1;
                  load_tgt = ras_top;
               end else begin
                  pc_d = pc_seq;
               end
            end
            if (load_en) begin
               pc_d = load_tgt & AlignMask;
               if (|(load_tgt & ~AlignMask)) begin
                  err_d = 1'b1;
               end
            end
         end
         default: state_d = StBoot;
      endcase
   end

   // Architectural state; reset takes effect immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StBoot;
         pc_q    <= RESET_VECTOR;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
      end
   end

`ifdef PC_UNIT_RAS_EN
   pc_ras #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc_seq),
      .top       (ras_top),
      .empty     (ras_empty_int)
   );
`else
   // Without the stack a return always falls through to the sequential path.
   logic unused_ras;
   assign unused_ras    = ^{ras_push, ras_pop};
   assign ras_top       = '0;
   assign ras_empty_int = 1'b1;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed scenarios plus random traffic against a queue-based model.
module tb_pc_unit;

   localparam int unsigned XLEN  = 32;
   localparam logic [31:0] RV    = 32'h100;
   localparam int unsigned DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
   localparam bit RasEn = 1'b1;
`else
   localparam bit RasEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_ready = 1'b0, fetch_valid;
   logic [31:0] pc;
   logic        trap_valid = 1'b0, redirect_valid = 1'b0, call_valid = 1'b0, ret_valid = 1'b0;
   logic [31:0] trap_target = '0, redirect_target = '0;
   logic        ras_empty, misaligned_err;

   pc_unit #(
      .XLEN         (XLEN),
      .RESET_VECTOR (RV),
      .INSTR_BYTES  (4),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_ready     (fetch_ready),
      .fetch_valid     (fetch_valid),
      .pc              (pc),
      .trap_valid      (trap_valid),
      .trap_target     (trap_target),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .call_valid      (call_valid),
      .ret_valid       (ret_valid),
      .ras_empty       (ras_empty),
      .misaligned_err  (misaligned_err)
   );

   always #5 clk = ~clk;

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   // Reference model: architectural pc, valid, sticky error and a return stack (newest at back).
   logic [31:0] m_pc;
   logic        m_valid, m_err;
   logic [31:0] m_ras[$];

   function automatic void model_reset();
      m_pc    = RV;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_ras.delete();
   endfunction

   function automatic void model_load(input logic [31:0] t);
      m_pc = {t[31:2], 2'b00};
      if (t[1:0] != 2'b00) m_err = 1'b1;
   endfunction

   function automatic void model_step();
      logic [31:0] seq;
      if (!m_valid) begin
         m_valid = 1'b1;
      end else if (trap_valid) begin
         model_load(trap_target);
      end else if (redirect_valid) begin
         model_load(redirect_target);
      end else if (fetch_ready) begin
         seq = m_pc + 32'd4;
         if (RasEn && ret_valid && m_ras.size() > 0) model_load(m_ras.pop_back());
         else m_pc = seq;
         if (RasEn && call_valid) begin
            m_ras.push_back(seq);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end
      end
   endfunction

   task automatic check_all(input string tag);
      check({tag, ".pc"}, pc, m_pc);
      check({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, m_valid});
      check({tag, ".empty"}, {31'd0, ras_empty}, {31'd0, (m_ras.size() == 0)});
      check({tag, ".err"}, {31'd0, misaligned_err}, {31'd0, m_err});
   endtask

   // One clock with the given inputs held across the rising edge.
   task automatic cyc(input string tag, input logic tv, input logic [31:0] tt, input logic rv,
                      input logic [31:0] rt, input logic cv, input logic retv, input logic rdy);
      trap_valid      = tv;
      trap_target     = tt;
      redirect_valid  = rv;
      redirect_target = rt;
      call_valid      = cv;
      ret_valid       = retv;
      fetch_ready     = rdy;
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic redir(input string tag, input logic [31:0] t);
      cyc(tag, 1'b0, '0, 1'b1, t, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic fire(input string tag, input logic cv, input logic retv);
      cyc(tag, 1'b0, '0, 1'b0, '0, cv, retv, 1'b1);
   endtask

   // Asynchronous assert checked before any edge, held over one edge, then released.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      model_reset();
      check_all({tag, ".async"});
      @(posedge clk);
      #1;
      check_all({tag, ".held"});
      reset = 1'b1;
   endtask

   initial begin
      logic [31:0] tgt;
      #1;
      do_reset("por");
      check("por.pc_const", pc, 32'h100);
      check("por.fv_const", {31'd0, fetch_valid}, 32'd0);
      cyc("boot", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      check("boot.fv_const", {31'd0, fetch_valid}, 32'd1);

      // Stall and advance from 0.
      redir("to0", 32'h0);
      fire("adv1", 1'b0, 1'b0);
      check("adv1.const", pc, 32'h4);
      fire("adv2", 1'b0, 1'b0);
      fire("adv3", 1'b0, 1'b0);
      check("adv3.const", pc, 32'hC);
      cyc("stall1", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      cyc("stall2", 1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
      check("stall.const", pc, 32'hC);

      // Trap beats redirect even while stalled.
      cyc("prio", 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
      check("prio.const", pc, 32'h80);

      // Misaligned redirect then wrap with a clean error flag.
      redir("mis", 32'h43);
      check("mis.pc_const", pc, 32'h40);
      check("mis.err_const", {31'd0, misaligned_err}, 32'd1);
      do_reset("mid");
      cyc("boot2", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      redir("top", 32'hFFFF_FFFC);
      fire("wrap", 1'b0, 1'b0);
      check("wrap.pc_const", pc, 32'h0);
      check("wrap.err_const", {31'd0, misaligned_err}, 32'd0);

      // Call/return and return on an empty stack.
      redir("c_at", 32'h10);
      fire("call", 1'b1, 1'b0);
      redir("r_at", 32'h50);
      fire("ret", 1'b0, 1'b1);
      check("ret.const", pc, RasEn ? 32'h14 : 32'h54);
      check("ret.empty_const", {31'd0, ras_empty}, 32'd1);
      redir("e_at", 32'h20);
      fire("ret_empty", 1'b0, 1'b1);
      check("ret_empty.const", pc, 32'h24);

      // Five calls into a four-deep stack, then five returns.
      for (int i = 1; i <= 5; i++) begin
         redir("ov_at", 32'h1000 * i);
         fire("ov_call", 1'b1, 1'b0);
      end
      redir("ov_base", 32'h9000);
      for (int i = 5; i >= 2; i--) begin
         fire("ov_ret", 1'b0, 1'b1);
         check("ov_ret.const", pc, RasEn ? (32'h1000 * i + 32'h4) : (32'h9000 + 32'h4 * (6 - i)));
      end
      fire("ov_ret5", 1'b0, 1'b1);
      check("ov_ret5.const", pc, RasEn ? 32'h2008 : 32'h9014);

      // Simultaneous call and return, then a reset that discards the stack.
      redir("cr_a", 32'h300);
      fire("cr_call", 1'b1, 1'b0);
      redir("cr_b", 32'h700);
      fire("cr_both", 1'b1, 1'b1);
      redir("cr_c", 32'hA00);
      fire("cr_ret", 1'b0, 1'b1);
      check("cr_ret.const", pc, RasEn ? 32'h704 : 32'hA04);
      fire("cr_call2", 1'b1, 1'b0);
      do_reset("rst_ras");
      cyc("boot3", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
      fire("post_rst_ret", 1'b0, 1'b1);
      check("post_rst_ret.const", pc, 32'h104);

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(63) == 0) begin
            do_reset("rnd_rst");
         end else begin
            case ($urandom_range(3))
               0: tgt = $urandom;
               1: tgt = $urandom & 32'hFFFF_FFFC;
               2: tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
               default: tgt = $urandom & 32'h0000_0FFC;
            endcase
            cyc("rnd", ($urandom_range(15) == 0), tgt, ($urandom_range(7) == 0), tgt ^ 32'h10,
                ($urandom_range(3) == 0), ($urandom_range(2) == 0), ($urandom_range(3) != 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
